// File: rtl/word_uart_tx.sv
// word_uart_tx: word FIFO feeding an 8N1 UART transmitter, LSB first, high byte of each word first.
// Build option WORD_UART_HEX_ASCII_EN sends each word as four uppercase ASCII hex digits then CR LF.
module word_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             uart_tx,
   output logic             busy,
   output logic [FIFO_AW:0] fifo_count
);

   localparam int                 DEPTH      = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   ZERO_COUNT = {(FIFO_AW + 1){1'b0}};
   localparam logic [FIFO_AW:0]   ONE_COUNT  = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
   localparam logic [15:0]        BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
`ifdef WORD_UART_HEX_ASCII_EN
   localparam logic [2:0]         LAST_BYTE  = 3'd5;
`else
   localparam logic [2:0]         LAST_BYTE  = 3'd1;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_e;

`ifdef WORD_UART_HEX_ASCII_EN
   function automatic logic [7:0] nibble_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         nibble_ascii = 8'h30 + {4'h0, nib};
      end else begin
         nibble_ascii = 8'h37 + {4'h0, nib};
      end
   endfunction

   function automatic logic [7:0] select_byte(input logic [15:0] w, input logic [2:0] idx);
      case (idx)
         3'd0:    select_byte = nibble_ascii(w[15:12]);
         3'd1:    select_byte = nibble_ascii(w[11:8]);
         3'd2:    select_byte = nibble_ascii(w[7:4]);
         3'd3:    select_byte = nibble_ascii(w[3:0]);
         3'd4:    select_byte = 8'h0D;
         default: select_byte = 8'h0A;
      endcase
   endfunction
`else
   function automatic logic [7:0] select_byte(input logic [15:0] w, input logic [2:0] idx);
      case (idx)
         3'd0:    select_byte = w[15:8];
         default: select_byte = w[7:0];
      endcase
   endfunction
`endif

   logic [15:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ready_q, busy_q, tx_q, tx_d;
   state_e             state_q, state_d;
   logic [15:0]        baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [2:0]         byte_idx_q, byte_idx_d;
   logic [15:0]        word_q, word_d;
   logic               push_s, pop_s, term_s;
   logic [7:0]         cur_byte_s;

   assign push_s     = word_valid & ready_q;
   assign term_s     = (baud_q == BAUD_LAST);
   assign cur_byte_s = select_byte(word_q, byte_idx_q);

   assign word_ready = ready_q;
   assign uart_tx    = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   // Serializer next state; the FIFO head is captured into word_q on the pop edge.
   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      pop_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != ZERO_COUNT) begin
               pop_s   = 1'b1;
               word_d  = mem_q[rd_ptr_q];
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            byte_idx_d = 3'd0;
            bit_d      = 3'd0;
            state_d    = START;
         end
         START: begin
            if (term_s) begin
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (term_s && (bit_q == 3'd7)) begin
               state_d = STOP;
            end else if (term_s) begin
               bit_d = bit_q + 3'd1;
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (term_s && (byte_idx_q == LAST_BYTE)) begin
               state_d = IDLE;
            end else if (term_s) begin
               byte_idx_d = byte_idx_q + 3'd1;
               bit_d      = 3'd0;
               state_d    = START;
            end else begin
               state_d = STOP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level for the coming cycle, so uart_tx switches together with the state.
   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte_s[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   // Baud counter restarts on every state entry and wraps at the terminal count.
   always_comb begin
      if ((state_d != state_q) || term_s) begin
         baud_d = 16'd0;
      end else if ((state_q == START) || (state_q == DATA) || (state_q == STOP)) begin
         baud_d = baud_q + 16'd1;
      end else begin
         baud_d = 16'd0;
      end
   end

   // FIFO occupancy after this cycle's push and pop.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + ONE_COUNT;
         2'b01:   count_d = count_q - ONE_COUNT;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= word_in;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= {FIFO_AW{1'b0}};
         rd_ptr_q   <= {FIFO_AW{1'b0}};
         count_q    <= ZERO_COUNT;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         tx_q       <= 1'b1;
         state_q    <= IDLE;
         baud_q     <= 16'd0;
         bit_q      <= 3'd0;
         byte_idx_q <= 3'd0;
         word_q     <= 16'h0000;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q    <= count_d;
         ready_q    <= (count_d != FULL_COUNT);
         busy_q     <= (count_d != ZERO_COUNT) || (state_d != IDLE);
         tx_q       <= tx_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
      end
   end

endmodule

// File: tb/tb_word_uart_tx.sv
// Directed bench for word_uart_tx with CLKS_PER_BIT=4 and a 4-word FIFO; a line monitor decodes frames.
module tb_word_uart_tx;

   localparam int CPB = 4;
   localparam int AW  = 2;
`ifdef WORD_UART_HEX_ASCII_EN
   localparam int BPW = 6;
`else
   localparam int BPW = 2;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [15:0]   word_in = 16'h0000;
   logic          word_valid = 1'b0;
   logic          word_ready;
   logic          uart_tx;
   logic          busy;
   logic [AW:0]   fifo_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] mon_bytes[$];
   logic       mon_stop[$];
   int         mon_start[$];

   word_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver: samples each bit mid-period on falling clock edges.
   initial begin
      bit         rx_act;
      int         rx_cnt;
      int         rx_st;
      logic [7:0] rx_sh;
      rx_act = 1'b0; rx_cnt = 0; rx_st = 0; rx_sh = 8'h00;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            rx_act = 1'b0;
         end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
               rx_act = 1'b1; rx_cnt = 0; rx_st = cyc;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) begin
               rx_sh = {uart_tx, rx_sh[7:1]};
            end else if (rx_cnt == 38) begin
               mon_bytes.push_back(rx_sh);
               mon_stop.push_back(uart_tx);
               mon_start.push_back(rx_st);
               rx_act = 1'b0;
            end
         end
      end
   end

   function automatic logic [7:0] exp_byte(input logic [15:0] w, input int k);
`ifdef WORD_UART_HEX_ASCII_EN
      logic [3:0] n;
      case (k)
         0:       n = w[15:12];
         1:       n = w[11:8];
         2:       n = w[7:4];
         default: n = w[3:0];
      endcase
      if (k == 4) return 8'h0D;
      if (k == 5) return 8'h0A;
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return 8'h41 + {4'h0, n - 4'd10};
`else
      return (k == 0) ? w[15:8] : w[7:0];
`endif
   endfunction

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0; word_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++; if (word_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", word_ready); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

`ifndef WORD_UART_HEX_ASCII_EN
   task automatic test_raw;
      logic [19:0] fr;
      logic        e;
      fr = 20'b01010010110010110101;
      @(negedge clk);
      word_in = 16'hA55A; word_valid = 1'b1;
      for (int i = 0; i <= 82; i++) begin
         @(negedge clk);
         word_valid = 1'b0;
         if (i < 2 || i == 82) e = 1'b1;
         else e = fr[19 - (i - 2) / 4];
         checks++;
         if (uart_tx !== e) begin failures++; $display("FAIL raw_tx[%0d]: got %b expected %b", i, uart_tx, e); end
         if (i == 0) begin
            checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL raw_count_push: got %0d expected 1", fifo_count); end
         end
         if (i == 1) begin
            checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL raw_count_pop: got %0d expected 0", fifo_count); end
         end
         if (i == 81) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL raw_busy_stop: got %b expected 1", busy); end
         end
         if (i == 82) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL raw_busy_drop: got %b expected 0", busy); end
         end
      end
   endtask

   task automatic test_back_to_back;
      bit         ok;
      logic [7:0] eb [4];
      eb[0] = 8'h12; eb[1] = 8'h34; eb[2] = 8'hAB; eb[3] = 8'hCD;
      mon_bytes.delete(); mon_stop.delete(); mon_start.delete();
      @(negedge clk);
      word_in = 16'h1234; word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      repeat (10) @(negedge clk);
      word_in = 16'hABCD; word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      wait_idle(1000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: busy still %b", busy); end
      checks++;
      if (mon_bytes.size() != 4) begin
         failures++; $display("FAIL b2b_nbytes: got %0d expected 4", mon_bytes.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++; if (mon_bytes[k] !== eb[k]) begin failures++; $display("FAIL b2b_byte%0d: got %h expected %h", k, mon_bytes[k], eb[k]); end
            checks++; if (mon_stop[k] !== 1'b1) begin failures++; $display("FAIL b2b_stop%0d: got %b expected 1", k, mon_stop[k]); end
         end
         checks++; if (mon_start[1] - mon_start[0] != 40) begin failures++; $display("FAIL b2b_gap01: got %0d expected 40", mon_start[1] - mon_start[0]); end
         checks++; if (mon_start[2] - mon_start[1] != 42) begin failures++; $display("FAIL b2b_gap12: got %0d expected 42", mon_start[2] - mon_start[1]); end
         checks++; if (mon_start[3] - mon_start[2] != 40) begin failures++; $display("FAIL b2b_gap23: got %0d expected 40", mon_start[3] - mon_start[2]); end
      end
   endtask
`else
   task automatic test_hex;
      bit         ok;
      logic [7:0] eb [6];
      eb[0] = 8'h30; eb[1] = 8'h46; eb[2] = 8'h33; eb[3] = 8'h43; eb[4] = 8'h0D; eb[5] = 8'h0A;
      mon_bytes.delete(); mon_stop.delete(); mon_start.delete();
      @(negedge clk);
      word_in = 16'h0F3C; word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      wait_idle(1000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL hex_timeout: busy still %b", busy); end
      checks++;
      if (mon_bytes.size() != 6) begin
         failures++; $display("FAIL hex_nbytes: got %0d expected 6", mon_bytes.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++; if (mon_bytes[k] !== eb[k]) begin failures++; $display("FAIL hex_byte%0d: got %h expected %h", k, mon_bytes[k], eb[k]); end
            if (k > 0) begin
               checks++; if (mon_start[k] - mon_start[k-1] != 40) begin failures++; $display("FAIL hex_gap%0d: got %0d expected 40", k, mon_start[k] - mon_start[k-1]); end
            end
         end
      end
   endtask
`endif

   task automatic test_simul;
      bit          ok;
      logic [15:0] w [2];
      w[0] = 16'hBEEF; w[1] = 16'h5A3C;
      mon_bytes.delete(); mon_stop.delete(); mon_start.delete();
      @(negedge clk);
      word_in = w[0]; word_valid = 1'b1;
      @(negedge clk);
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL simul_count_first: got %0d expected 1", fifo_count); end
      word_in = w[1];
      @(negedge clk);
      word_valid = 1'b0;
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL simul_count_pushpop: got %0d expected 1", fifo_count); end
      wait_idle(1500, ok);
      checks++; if (!ok) begin failures++; $display("FAIL simul_timeout: busy still %b", busy); end
      checks++;
      if (mon_bytes.size() != 2 * BPW) begin
         failures++; $display("FAIL simul_nbytes: got %0d expected %0d", mon_bytes.size(), 2 * BPW);
      end else begin
         for (int k = 0; k < 2 * BPW; k++) begin
            checks++;
            if (mon_bytes[k] !== exp_byte(w[k / BPW], k % BPW)) begin
               failures++; $display("FAIL simul_byte%0d: got %h expected %h", k, mon_bytes[k], exp_byte(w[k / BPW], k % BPW));
            end
         end
      end
   endtask

   task automatic test_fill;
      bit          ok, acc, saw_full;
      int          idx, guard;
      logic [15:0] w [6];
      w[0] = 16'hC001; w[1] = 16'h2BAD; w[2] = 16'h3E57;
      w[3] = 16'h4A61; w[4] = 16'h5F0D; w[5] = 16'h6789;
      mon_bytes.delete(); mon_stop.delete(); mon_start.delete();
      saw_full = 1'b0; idx = 0; guard = 0;
      @(negedge clk);
      word_in = w[0]; word_valid = 1'b1;
      acc = word_ready;
      while (idx < 6 && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (acc) begin
            idx++;
            if (idx < 6) word_in = w[idx];
            else word_valid = 1'b0;
         end
         if (fifo_count === 3'd4) begin
            saw_full = 1'b1;
            checks++; if (word_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_full: got %b expected 0", word_ready); end
         end
         acc = word_ready & word_valid;
         if (acc && idx == 5) begin
            checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL fill_w6_after_pop: count %0d expected 3", fifo_count); end
         end
      end
      checks++; if (!saw_full) begin failures++; $display("FAIL fill_reach_full: max count not 4"); end
      checks++; if (idx != 6) begin failures++; $display("FAIL fill_accepted: got %0d expected 6", idx); end
      wait_idle(5000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fill_timeout: busy still %b", busy); end
      checks++;
      if (mon_bytes.size() != 6 * BPW) begin
         failures++; $display("FAIL fill_nbytes: got %0d expected %0d", mon_bytes.size(), 6 * BPW);
      end else begin
         for (int k = 0; k < 6 * BPW; k++) begin
            checks++;
            if (mon_bytes[k] !== exp_byte(w[k / BPW], k % BPW)) begin
               failures++; $display("FAIL fill_byte%0d: got %h expected %h", k, mon_bytes[k], exp_byte(w[k / BPW], k % BPW));
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      mon_bytes.delete(); mon_stop.delete(); mon_start.delete();
      @(negedge clk);
      word_in = 16'h7700; word_valid = 1'b1;
      @(negedge clk); word_in = 16'h1357;
      @(negedge clk); word_in = 16'h2468;
      @(negedge clk); word_in = 16'h9ABC;
      @(negedge clk); word_valid = 1'b0;
      repeat (16) @(negedge clk);
      checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL mid_count_before: got %0d expected 3", fifo_count); end
      checks++; if (uart_tx !== 1'b0) begin failures++; $display("FAIL mid_tx_bit3: got %b expected 0", uart_tx); end
      reset = 1'b0;
      #1;
      checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL mid_tx_async: got %b expected 1", uart_tx); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
      checks++; if (word_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b expected 1", word_ready); end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         checks++;
         if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_quiet[%0d]: tx %b busy %b expected 1 0", i, uart_tx, busy);
         end
      end
      checks++; if (mon_bytes.size() != 0) begin failures++; $display("FAIL mid_nbytes: got %0d expected 0", mon_bytes.size()); end
   endtask

   initial begin
      test_reset();
`ifndef WORD_UART_HEX_ASCII_EN
      test_raw();
      test_back_to_back();
`else
      test_hex();
`endif
      test_simul();
      test_fill();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
